// File: rtl/flip_select_sequencer.sv
// ---------------------------------------------------------------------------
// flip_select_sequencer
//
// Upstream controller for the variable flip selector. Takes one unsatisfied
// clause (up to NSAT variable indices plus slot-occupied flags). It fetches
// each variable's clause-broken and mask bits from the variable-clause
// memory and streams them into the selector with the write-enable sequence
// 01, 10, 11. It then captures the selected literal and offers the chosen
// variable and its clause-valid bits downstream.
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   clause_valid_i / clause_ready_o     clause handshake (ready only in IDLE)
//   clause_vars_i                       NSAT packed variable indices, slot n at
//                                       [n*VAR_BITS +: VAR_BITS]
//   clause_lits_valid_i                 slot-occupied flags
//   rd_en_o / rd_addr_o                 memory read strobe and address
//   rd_broken_i / rd_mask_i             memory data, one cycle after rd_en_o
//   clause_broken_o / mask_bits_o       per-slot data toward the selector
//   break_values_valid_o / wr_en_o      selector control
//   selected_i / clause_valid_bits_i    selector result
//   flip_valid_o / flip_ready_i         flip handshake
//   flip_var_o / flip_clause_bits_o     chosen variable and its clause bits
//   err_o                               one-cycle pulse when a clause is dropped
//   flip_count_o                        saturating count of accepted flips
// ---------------------------------------------------------------------------
module flip_select_sequencer #(
    parameter int NSAT                     = 3,
    parameter int MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int VAR_BITS                 = 16,
    localparam int NSAT_BITS               = $clog2(NSAT)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clause_valid_i,
    output logic                                clause_ready_o,
    input  logic [NSAT*VAR_BITS-1:0]            clause_vars_i,
    input  logic [NSAT-1:0]                     clause_lits_valid_i,
    output logic                                rd_en_o,
    output logic [VAR_BITS-1:0]                 rd_addr_o,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] rd_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] rd_mask_i,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
    output logic [NSAT-1:0]                     break_values_valid_o,
    output logic [NSAT_BITS-1:0]                wr_en_o,
    input  logic [NSAT_BITS-1:0]                selected_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_valid_bits_i,
    output logic                                flip_valid_o,
    input  logic                                flip_ready_i,
    output logic [VAR_BITS-1:0]                 flip_var_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] flip_clause_bits_o,
    output logic                                err_o,
    output logic [31:0]                         flip_count_o
);

    localparam int MC = MAX_CLAUSES_PER_VARIABLE;

    // The three-step write sequence below is hard-wired for three slots.
    if (NSAT != 3) begin : g_nsat_check
        $error("flip_select_sequencer: NSAT must be 3");
    end

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD0  = 3'd1;
    localparam logic [2:0] ST_WR0  = 3'd2;
    localparam logic [2:0] ST_WR1  = 3'd3;
    localparam logic [2:0] ST_WR2  = 3'd4;
    localparam logic [2:0] ST_CAP  = 3'd5;
    localparam logic [2:0] ST_OUT  = 3'd6;

    logic [2:0]               state_reg, state_next;
    logic [NSAT*VAR_BITS-1:0] vars_reg;
    logic [NSAT-1:0]          lits_reg;
    logic [VAR_BITS-1:0]      flip_var_reg;
    logic [MC-1:0]            flip_bits_reg;
    logic                     err_reg, err_next;
    logic [31:0]              flip_count_reg;

    logic [VAR_BITS-1:0]      vars_q [NSAT];
    logic                     accept;
    logic                     sel_ok;
    logic [VAR_BITS-1:0]      sel_var;

    for (genvar gi = 0; gi < NSAT; gi++) begin : g_slot
        assign vars_q[gi] = vars_reg[gi*VAR_BITS +: VAR_BITS];
    end

    assign accept = (state_reg == ST_IDLE) && clause_valid_i;

    // A selection is usable only if it names an existing, occupied slot;
    // out-of-range codes never match the loop and leave sel_ok low.
    always_comb begin
        sel_ok  = 1'b0;
        sel_var = '0;
        for (int i = 0; i < NSAT; i++) begin
            if (selected_i == NSAT_BITS'(i)) begin
                sel_ok  = lits_reg[i];
                sel_var = vars_q[i];
            end
        end
    end

    // Each WRk state forwards the memory data requested in the previous
    // state and issues the read for the following slot, so reads and
    // selector writes overlap by one cycle.
    always_comb begin
        state_next           = state_reg;
        err_next             = 1'b0;
        clause_ready_o       = 1'b0;
        rd_en_o              = 1'b0;
        rd_addr_o            = '0;
        clause_broken_o      = '0;
        mask_bits_o          = '0;
        break_values_valid_o = '0;
        wr_en_o              = '0;
        flip_valid_o         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                clause_ready_o = 1'b1;
                if (clause_valid_i) begin
                    if (|clause_lits_valid_i) begin
                        state_next = ST_RD0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_RD0: begin
                rd_en_o    = lits_reg[0];
                rd_addr_o  = vars_q[0];
                state_next = ST_WR0;
            end
            ST_WR0: begin
                wr_en_o         = NSAT_BITS'(1);
                clause_broken_o = lits_reg[0] ? rd_broken_i : '0;
                mask_bits_o     = lits_reg[0] ? rd_mask_i : '0;
                rd_en_o         = lits_reg[1];
                rd_addr_o       = vars_q[1];
                state_next      = ST_WR1;
            end
            ST_WR1: begin
                wr_en_o         = NSAT_BITS'(2);
                clause_broken_o = lits_reg[1] ? rd_broken_i : '0;
                mask_bits_o     = lits_reg[1] ? rd_mask_i : '0;
                rd_en_o         = lits_reg[2];
                rd_addr_o       = vars_q[2];
                state_next      = ST_WR2;
            end
            ST_WR2: begin
                wr_en_o              = NSAT_BITS'(3);
                clause_broken_o      = lits_reg[2] ? rd_broken_i : '0;
                mask_bits_o          = lits_reg[2] ? rd_mask_i : '0;
                break_values_valid_o = lits_reg;
                state_next           = ST_CAP;
            end
            ST_CAP: begin
                if (sel_ok) begin
                    state_next = ST_OUT;
                end else begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_OUT: begin
                flip_valid_o = 1'b1;
                if (flip_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            vars_reg       <= '0;
            lits_reg       <= '0;
            flip_var_reg   <= '0;
            flip_bits_reg  <= '0;
            err_reg        <= 1'b0;
            flip_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (accept) begin
                vars_reg <= clause_vars_i;
                lits_reg <= clause_lits_valid_i;
            end
            if ((state_reg == ST_CAP) && sel_ok) begin
                flip_var_reg  <= sel_var;
                flip_bits_reg <= clause_valid_bits_i;
            end
            if ((state_reg == ST_OUT) && flip_ready_i && (flip_count_reg != 32'hFFFF_FFFF)) begin
                flip_count_reg <= flip_count_reg + 32'd1;
            end
        end
    end

    assign flip_var_o         = flip_var_reg;
    assign flip_clause_bits_o = flip_bits_reg;
    assign err_o              = err_reg;
    assign flip_count_o       = flip_count_reg;

endmodule

// File: doc/flip_select_sequencer.md
Name: flip_select_sequencer

Overview:
- Upstream controller for the variable flip selector.
- Accepts one unsatisfied clause, given as up to NSAT variable indices, and reads each variable's clause-broken and mask bits from the variable-clause memory.
- Drives the selector's write-enable sequence (01, 10, 11), captures the selected literal, and hands the chosen variable index plus its clause-valid bits downstream over a valid/ready handshake.

Parameters:
- NSAT, 3, literals per clause. This revision requires exactly 3; any other value is an elaboration error.
- MAX_CLAUSES_PER_VARIABLE, 20, width of the clause bit vectors (MC).
- VAR_BITS, 16, width of a variable index.
- NSAT_BITS, $clog2(NSAT), localparam, width of wr_en_o and selected_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- clause_valid_i  in  1  clause offer.
- clause_ready_o  out  1  sequencer can accept a clause.
- clause_vars_i  in  NSAT*VAR_BITS  variable index per slot; slot n is at [n*VAR_BITS +: VAR_BITS].
- clause_lits_valid_i  in  NSAT  slot-occupied flags.
- rd_en_o  out  1  memory read strobe.
- rd_addr_o  out  VAR_BITS  memory read address (variable index).
- rd_broken_i  in  MC  broken bits returned 1 cycle after rd_en_o.
- rd_mask_i  in  MC  mask bits returned 1 cycle after rd_en_o.
- clause_broken_o  out  MC  to selector clause_broken_i.
- mask_bits_o  out  MC  to selector mask_bits_i.
- break_values_valid_o  out  NSAT  to selector break_values_valid_i.
- wr_en_o  out  NSAT_BITS  to selector wr_en_i.
- selected_i  in  NSAT_BITS  from selector selected_o.
- clause_valid_bits_i  in  MC  from selector clause_valid_bits_o.
- flip_valid_o  out  1  flip result valid.
- flip_ready_i  in  1  downstream accepts the flip.
- flip_var_o  out  VAR_BITS  variable to flip.
- flip_clause_bits_o  out  MC  clause-valid bits of the chosen literal.
- err_o  out  1  one-cycle pulse: clause dropped.
- flip_count_o  out  32  count of flips handed off, saturating.

Behaviour:
- Reset (asynchronous, rst_ni=0): state goes to IDLE. All outputs are 0, except clause_ready_o, which is 1 in IDLE. Latched clause data and flip_count_o are cleared. An in-flight clause is discarded with no error pulse.
- FSM states: IDLE, RD0, WR0, WR1, WR2, CAP, OUT.
- IDLE:
  - clause_ready_o=1, the only state in which it is 1.
  - On clause_valid_i&clause_ready_o, latch vars and lits_valid, then go to RD0.
  - If the latched lits_valid would be 000, go straight to IDLE instead and pulse err_o the next cycle.
- RD0: rd_en_o=lits_valid[0], rd_addr_o=var0.
- WR0:
  - clause_broken_o=rd_broken_i and mask_bits_o=rd_mask_i if slot 0 is valid, else both 0.
  - wr_en_o=01.
  - Read slot 1 as in RD0.
- WR1: same as WR0 for slot 1; wr_en_o=10; read slot 2.
- WR2: slot 2 data; wr_en_o=11; break_values_valid_o=latched lits_valid.
- break_values_valid_o is 0 in every state except WR2. wr_en_o is 00 outside WR0–WR2. rd_en_o is 0 outside RD0, WR0 and WR1.
- CAP:
  - The selector outputs are now updated.
  - If selected_i<NSAT and lits_valid[selected_i]=1: register flip_var_o=var[selected_i] and flip_clause_bits_o=clause_valid_bits_i, then go to OUT.
  - Otherwise pulse err_o next cycle and go to IDLE.
- OUT:
  - flip_valid_o=1; flip_var_o and flip_clause_bits_o are held stable until the handshake.
  - On flip_ready_i=1: go to IDLE, increment flip_count_o (saturates at 0xFFFFFFFF).
  - flip_valid_o must not drop before acceptance.
- Latency: acceptance at edge T gives flip_valid_o=1 from T+6 onward. With ready held high, throughput is one clause per 7 cycles.
- Simultaneous events: clause_valid_i is ignored outside IDLE. flip_ready_i is ignored outside OUT.
- Input data is sampled only at acceptance. Later changes to clause_vars_i do not affect the clause in flight.

Test Plan:
- Reset: assert rst_ni=0 mid-WR1 -> immediately wr_en_o=00, rd_en_o=0, clause_ready_o=1, flip_valid_o=0; the next clause completes normally.
- Nominal:
  - Stimulus: vars {5,9,12}, lits_valid=111; memory returns the bit patterns for var 9 and the other two vars; selector model returns selected=01 with bits 0x00003; flip_ready_i=1.
  - Response: wr_en_o sequence 01,10,11 on T+2..T+4; rd_addr_o 5,9,12 on T+1..T+3; flip_valid_o at T+6 with flip_var_o=9, flip_clause_bits_o=0x00003; flip_count_o=1.
- Invalid slot:
  - Stimulus: lits_valid=101, vars {3,7,4}.
  - Response: no read for 7 (rd_en_o=0 at T+2); clause_broken_o=mask_bits_o=0 during WR1; break_values_valid_o=101 in WR2.
- Bad select:
  - Case 1: selector returns 11 -> err_o pulses once, no flip_valid_o, back to IDLE.
  - Case 2: lits_valid=000 -> err_o pulse, no reads issued.
- Backpressure: hold flip_ready_i=0 for 10 cycles -> flip_valid_o, flip_var_o and flip_clause_bits_o stay stable and clause_ready_o=0 throughout; accepted on the cycle flip_ready_i rises.
- Saturation: force flip_count_o=0xFFFFFFFE, perform 2 flips -> count reads 0xFFFFFFFF after each.
